// File: rtl/crypto_control_unit.sv
// crypto_control_unit
//
// Multi-cycle sequencer for the mini crypto processor. Fetches 16-bit
// instructions, holds the current one in an instruction register that feeds
// an external combinational decoder, and issues register-file / ALU control
// for the ALU opcodes. Also handles JMP and HALT and keeps the program counter.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  leave IDLE and begin fetching at address 0
//   imem_req/imem_addr     fetch request (whole FETCH state) and address (= pc)
//   imem_rdata/imem_valid  instruction word and its valid strobe
//   instr                  instruction register, drives the decoder
//   opcode/reg1/reg2/imm   decoder fields read back from the decoder
//   rf_raddr_a/_b, rf_waddr, rf_we         register-file control
//   alu_op, alu_use_imm, alu_en            ALU control
//   busy, halted, illegal, instr_count     status
//   dbg_state              current FSM state, for observation only
//
// Fetch handshake: imem_req is held high for every cycle of FETCH. The word is
// taken on the first rising edge at which imem_req=1 and imem_valid=1; that
// same edge moves the FSM to DECODE, so imem_req drops in the next cycle.
// imem_valid is ignored whenever imem_req=0.

module crypto_control_unit #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_valid,
    output logic [15:0]       instr,
    input  logic [3:0]        opcode,
    input  logic [3:0]        reg1,
    input  logic [3:0]        reg2,
    input  logic [3:0]        imm,
    output logic [3:0]        rf_raddr_a,
    output logic [3:0]        rf_raddr_b,
    output logic [3:0]        rf_waddr,
    output logic              rf_we,
    output logic [2:0]        alu_op,
    output logic              alu_use_imm,
    output logic              alu_en,
    output logic              busy,
    output logic              halted,
    output logic              illegal,
    output logic [15:0]       instr_count,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        WRITEBACK = 3'd4,
        HALT      = 3'd5
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc;

    // Opcode classification from the decoder fields.
    logic       op_is_alu;
    logic       op_is_jmp;
    logic       op_is_halt;
    logic       op_is_undef;
    logic [2:0] op_alu_code;
    logic       op_uses_imm;

    always_comb begin
        op_is_alu   = 1'b0;
        op_is_jmp   = 1'b0;
        op_is_halt  = 1'b0;
        op_is_undef = 1'b0;
        op_alu_code = 3'd0;
        op_uses_imm = 1'b0;
        case (opcode)
            4'h0: ;
            4'h1: begin op_is_alu = 1'b1; op_alu_code = 3'd0; end
            4'h2: begin op_is_alu = 1'b1; op_alu_code = 3'd1; end
            4'h3: begin op_is_alu = 1'b1; op_alu_code = 3'd2; end
            4'h4: begin op_is_alu = 1'b1; op_alu_code = 3'd3; end
            4'h5: begin op_is_alu = 1'b1; op_alu_code = 3'd4; end
            4'h6: begin op_is_alu = 1'b1; op_alu_code = 3'd4; op_uses_imm = 1'b1; end
            4'h7: op_is_jmp = 1'b1;
            4'hF: op_is_halt = 1'b1;
            default: op_is_undef = 1'b1;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (start) state_next = FETCH;
            FETCH:     if (imem_valid) state_next = DECODE;
            DECODE:    state_next = EXECUTE;
            EXECUTE:   state_next = op_is_halt ? HALT : WRITEBACK;
            WRITEBACK: state_next = FETCH;
            HALT:      state_next = HALT;
            default:   state_next = IDLE;
        endcase
    end

    // Outputs decoded from the registered state and the registered instruction.
    always_comb begin
        imem_req    = (state == FETCH);
        imem_addr   = pc;
        rf_raddr_a  = reg1;
        rf_raddr_b  = reg2;
        rf_waddr    = reg1;
        alu_en      = (state == EXECUTE) && op_is_alu;
        alu_op      = (state == EXECUTE) ? op_alu_code : 3'd0;
        alu_use_imm = (state == EXECUTE) && op_uses_imm;
        rf_we       = (state == WRITEBACK) && op_is_alu;
        busy        = (state != IDLE) && (state != HALT);
        halted      = (state == HALT);
        dbg_state   = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= '0;
            instr       <= '0;
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) pc <= '0;
                end
                FETCH: begin
                    if (imem_valid) instr <= imem_rdata;
                end
                EXECUTE: begin
                    if (op_is_jmp)   pc <= ADDR_W'(imm);
                    if (op_is_undef) illegal <= 1'b1;
                    // HALT retires here because it never reaches WRITEBACK.
                    if (op_is_halt)  instr_count <= instr_count + 16'd1;
                end
                WRITEBACK: begin
                    // JMP already loaded pc in EXECUTE.
                    if (!op_is_jmp) pc <= pc + ADDR_W'(1);
                    instr_count <= instr_count + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
